// File: rtl/ifq_wide_if.sv
// Bundles the instruction-cache request/response side and the dispatch side of ifq_wide.
// master is the queue itself; slave is the cache/dispatch environment around it.
interface ifq_wide_if #(
  parameter int WORDS = 4,
  parameter int CW    = 5
);
  // Handshake rules:
  // - icache_rd_en requests the line at icache_pc_in.
  // - icache_dout_valid presents a line, which is accepted only when the queue is not full
  //   and no redirect is active; otherwise it is dropped, never stalled.
  // - dispatch_rd_en pops the head word only when dispatch_empty is low.
  // - dispatch_branch_valid is a one-cycle strobe that overrides everything else.
  logic [31:0]         icache_pc_in;
  logic                icache_rd_en;
  logic                icache_abort;
  logic [32*WORDS-1:0] icache_dout;
  logic                icache_dout_valid;
  logic [31:0]         dispatch_pc_out;
  logic [31:0]         dispatch_inst;
  logic                dispatch_empty;
  logic                dispatch_rd_en;
  logic [31:0]         dispatch_branch_addr;
  logic                dispatch_branch_valid;
  logic [CW-1:0]       ifq_count;

  modport master (
    output icache_pc_in, icache_rd_en, icache_abort,
    output dispatch_pc_out, dispatch_inst, dispatch_empty, ifq_count,
    input  icache_dout, icache_dout_valid,
    input  dispatch_rd_en, dispatch_branch_addr, dispatch_branch_valid
  );

  modport slave (
    input  icache_pc_in, icache_rd_en, icache_abort,
    input  dispatch_pc_out, dispatch_inst, dispatch_empty, ifq_count,
    output icache_dout, icache_dout_valid,
    output dispatch_rd_en, dispatch_branch_addr, dispatch_branch_valid
  );
endinterface

// File: rtl/ifq_wide.sv
// Instruction fetch queue: stores whole cache lines, dispatches one 32-bit word per pop,
// and restarts fetch on a dispatch redirect.
module ifq_wide #(
  parameter int          DEPTH    = 4,
  parameter int          WORDS    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic      clk,
  input logic      reset,
  ifq_wide_if.master bus
);
  localparam int LW = $clog2(WORDS);
  localparam int DW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH*WORDS) + 1;
  localparam int PW = DW + 1 + LW;
  localparam logic [31:0] LINE_BYTES = 32'(4*WORDS);

  logic [32*WORDS-1:0] line_mem [DEPTH];

  logic [DW:0]    wptr_r;
  logic [PW-1:0]  rptr_r;
  logic [31:0]    pc_out_r;
  logic [31:0]    fetch_pc_r;

  logic [DW:0]    rline;
  logic [DW-1:0]  rslot;
  logic [LW-1:0]  rword;
  logic           empty;
  logic           full;
  logic           branch;
  logic           wr_fire;
  logic           rd_fire;
  logic [31:0]    branch_line;
  logic [CW-1:0]  count_raw;

  assign rline  = rptr_r[DW+LW:LW];
  assign rslot  = rptr_r[DW+LW-1:LW];
  assign rword  = rptr_r[LW-1:0];
  assign branch = bus.dispatch_branch_valid;

  // Line-granular comparison: a partly consumed head line still occupies its slot.
  assign empty = (rline == wptr_r);
  assign full  = ((rline ^ wptr_r) == {1'b1, {DW{1'b0}}});

  assign branch_line = {bus.dispatch_branch_addr[31:LW+2], {(LW+2){1'b0}}};

  assign wr_fire = bus.icache_dout_valid & ~full & ~branch & ~reset;
  assign rd_fire = bus.dispatch_rd_en & ~empty & ~branch & ~reset;

  assign count_raw = {wptr_r, {LW{1'b0}}} - rptr_r;

  assign bus.icache_rd_en    = ~full & ~branch & ~reset;
  assign bus.icache_pc_in    = branch ? branch_line : fetch_pc_r;
  assign bus.icache_abort    = branch & ~reset;
  assign bus.dispatch_empty  = empty | branch | reset;
  assign bus.ifq_count       = reset ? '0 : count_raw;
  assign bus.dispatch_pc_out = pc_out_r;
  assign bus.dispatch_inst   = line_mem[rslot][{rword, 5'd0} +: 32];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      pc_out_r   <= RESET_PC;
      fetch_pc_r <= RESET_PC;
    end else if (branch) begin
      // Starting the read pointer mid-line skips the words ahead of the target.
      wptr_r     <= '0;
      rptr_r     <= {{(DW+1){1'b0}}, bus.dispatch_branch_addr[LW+1:2]};
      pc_out_r   <= bus.dispatch_branch_addr;
      fetch_pc_r <= branch_line + LINE_BYTES;
    end else begin
      if (wr_fire) begin
        wptr_r     <= wptr_r + 1'b1;
        fetch_pc_r <= fetch_pc_r + LINE_BYTES;
      end
      if (rd_fire) begin
        rptr_r   <= rptr_r + 1'b1;
        pc_out_r <= pc_out_r + 32'd4;
      end
    end
  end

  // Line storage carries no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      line_mem[wptr_r[DW-1:0]] <= bus.icache_dout;
    end
  end
endmodule

// File: doc/ifq_wide.md
IFQ_WIDE -- requirements
Module: ifq_wide

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4: queue depth in cache lines; power of 2, at least 2.
REQ-002 The module SHALL have parameter WORDS, default 4: 32-bit instructions per cache line; power of 2, at least 2.
REQ-003 The module SHALL have parameter RESET_PC, default 32'h0: first fetch address after reset; aligned to a line boundary.
REQ-004 The module SHALL define local widths: LW=clog2(WORDS), DW=clog2(DEPTH), CW=clog2(DEPTH*WORDS)+1.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous reset, active-high.
REQ-007 icache_pc_in  out  32  line-aligned fetch address.
REQ-008 icache_rd_en  out  1  fetch request.
REQ-009 icache_abort  out  1  cancels the in-flight fetch.
REQ-010 icache_dout  in  32*WORDS  fetched line; word i is at bits [32i+31:32i].
REQ-011 icache_dout_valid  in  1  icache_dout holds the response to the oldest unaborted request.
REQ-012 dispatch_pc_out  out  32  PC of the head instruction.
REQ-013 dispatch_inst  out  32  head instruction.
REQ-014 dispatch_empty  out  1  no valid head instruction.
REQ-015 dispatch_rd_en  in  1  pop the head instruction.
REQ-016 dispatch_branch_addr  in  32  redirect target; word-aligned.
REQ-017 dispatch_branch_valid  in  1  redirect strobe, single cycle.
REQ-018 ifq_count  out  CW  number of valid instructions queued.

Function
REQ-019 Storage SHALL be DEPTH line slots, with write pointer wptr_r (DW+1 bits, including a wrap bit) in lines and read pointer rptr_r (DW+1+LW bits) in words.
REQ-020 Empty SHALL be rptr_r[DW+LW:LW] == wptr_r; full SHALL be the two pointers differing only in the wrap bit, both evaluated on registered pointers.
REQ-021 ifq_count SHALL be (wptr_r*WORDS - rptr_r) evaluated modulo 2^(DW+1+LW).
REQ-022 icache_rd_en SHALL be ~full & ~dispatch_branch_valid & ~reset.
REQ-023 icache_pc_in SHALL be the line-aligned branch address when dispatch_branch_valid is high, else fetch_pc_r.
REQ-024 Write: icache_dout_valid & ~full & ~dispatch_branch_valid SHALL store the line at slot wptr_r[DW-1:0], increment wptr_r, and add 4*WORDS to fetch_pc_r.
REQ-025 A valid response while full SHALL be dropped, with no pointer or PC change.
REQ-026 Pop: dispatch_rd_en & ~empty & ~dispatch_branch_valid SHALL increment rptr_r by 1 and add 4 to pc_out_r.
REQ-027 dispatch_rd_en while empty SHALL be ignored.
REQ-028 A line slot SHALL be freed when its last word is popped; a write and a pop in the same cycle are both honoured.
REQ-029 Full SHALL use registered state, so a write is refused in the cycle the full queue frees a slot.
REQ-030 dispatch_inst SHALL be word rptr_r[LW-1:0] of slot rptr_r[DW+LW-1:LW]; dispatch_pc_out SHALL be pc_out_r.
REQ-031 Read latency SHALL be 1 cycle, with no bypass: a line written at edge N is visible after edge N.
REQ-032 Redirect (dispatch_branch_valid=1) SHALL, in the same cycle:
- assert icache_abort;
- force dispatch_empty=1;
- drop any icache_dout_valid.
REQ-033 At the next edge, a redirect SHALL:
- set wptr_r=0;
- set rptr_r = {0, dispatch_branch_addr[LW+1:2]};
- set pc_out_r = dispatch_branch_addr;
- set fetch_pc_r = line-aligned branch address + 4*WORDS.
REQ-034 The leading words of the first line before the branch target SHALL never be dispatched.
REQ-035 A redirect SHALL take priority over simultaneous write, pop and full conditions.
REQ-036 After a redirect, the first response accepted SHALL be the line containing the branch target.
REQ-037 Pointer wrap-around SHALL be modular; no pointer saturates.

Reset
REQ-038 On reset, all of the following SHALL hold:
- pointers = 0;
- pc_out_r = RESET_PC;
- fetch_pc_r = RESET_PC.
REQ-039 While reset is high, outputs SHALL be icache_rd_en=0, icache_abort=0, dispatch_empty=1, ifq_count=0.
REQ-040 Line storage SHALL need no reset.
REQ-041 Reset mid-operation SHALL discard all queued lines and in-flight responses.
REQ-042 After reset, the first fetch SHALL be icache_pc_in=RESET_PC.

Verification (DEPTH=4, WORDS=4)
REQ-043 Fill: 4 back-to-back responses with no pops -> ifq_count=16, icache_rd_en=0; a 5th valid response is dropped and the count stays 16.
REQ-044 Drain: from full, pop 16 instructions -> dispatch_pc_out = 0x00,0x04,...,0x3C, then dispatch_empty=1; icache_rd_en rises after the 4th pop.
REQ-045 Unaligned redirect: branch to 0x1008 -> icache_pc_in=0x1000 with icache_abort=1; after the response, dispatch_pc_out=0x1008, ifq_count=2, next fetch 0x1010.
REQ-046 Branch collision: branch with icache_dout_valid=1 and dispatch_rd_en=1 in the same cycle -> response dropped, no pop, ifq_count=0 next cycle.
REQ-047 Wrap: run 10 lines through with interleaved pops -> instruction order and PCs continuous across the pointer wrap.
REQ-048 Reset at ifq_count=9 -> next cycle dispatch_empty=1, ifq_count=0, icache_pc_in=RESET_PC.
